// File: rtl/rv_pkg.sv
// Shared RV32I datapath constants and basic types.
// Pure declarations; no logic, no latency, no flow control.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [AW-1:0]   reg_addr_t;

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational register-file read port with x0 masking.
// Zero latency; no backpressure. Optional write-first forwarding under REG_FILE_BYPASS_EN.
module reg_file_rdport
    import rv_pkg::*;
(
    input  logic [NREG-1:0][XLEN-1:0] regs_i,
    input  logic [AW-1:0]             rs_i,
`ifdef REG_FILE_BYPASS_EN
    input  logic                      we_i,
    input  logic [AW-1:0]             wa_i,
    input  logic [XLEN-1:0]           wd_i,
`endif
    output logic [XLEN-1:0]           rd_o
);

    logic rs_is_x0;

    assign rs_is_x0 = (rs_i == '0);

`ifdef REG_FILE_BYPASS_EN
    logic fwd_hit;

    // Forward only real writes; a write to x0 never reaches a reader.
    assign fwd_hit = we_i && (wa_i != '0) && (wa_i == rs_i);

    always_comb begin
        rd_o = regs_i[rs_i];
        if (rs_is_x0) begin
            rd_o = '0;
        end else if (fwd_hit) begin
            rd_o = wd_i;
        end
    end
`else
    always_comb begin
        rd_o = regs_i[rs_i];
        if (rs_is_x0) begin
            rd_o = '0;
        end
    end
`endif

endmodule

// File: rtl/reg_file.sv
// RV32I 32x32 register file: two combinational read ports, one write port, x0 hardwired to 0.
// Reads zero latency, writes visible after the next rising edge; no backpressure.
// REG_FILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module reg_file
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            RegW,
    input  logic [AW-1:0]   Rs1,
    input  logic [AW-1:0]   Rs2,
    input  logic [AW-1:0]   Rd,
    input  logic [XLEN-1:0] Wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    // x0 has no storage; entry 0 of the read table is tied to zero.
    logic [XLEN-1:0]           regs_q [1:NREG-1];
    logic [XLEN-1:0]           regs_d [1:NREG-1];
    logic [NREG-1:0][XLEN-1:0] rd_table;
    logic                      wr_en;

    assign wr_en = RegW && (Rd != '0);

    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[Rd] = Wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd_table[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            rd_table[i] = regs_q[i];
        end
    end

    reg_file_rdport u_rdport1 (
        .regs_i (rd_table),
        .rs_i   (Rs1),
`ifdef REG_FILE_BYPASS_EN
        .we_i   (RegW),
        .wa_i   (Rd),
        .wd_i   (Wd),
`endif
        .rd_o   (rd1)
    );

    reg_file_rdport u_rdport2 (
        .regs_i (rd_table),
        .rs_i   (Rs2),
`ifdef REG_FILE_BYPASS_EN
        .we_i   (RegW),
        .wa_i   (Rd),
        .wd_i   (Wd),
`endif
        .rd_o   (rd2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REG_FILE_BYPASS_EN.
module tb_reg_file;
    import rv_pkg::*;

    logic            clk;
    logic            rst;
    logic            RegW;
    logic [AW-1:0]   Rs1;
    logic [AW-1:0]   Rs2;
    logic [AW-1:0]   Rd;
    logic [XLEN-1:0] Wd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    int checks   = 0;
    int failures = 0;

    reg_file dut (
        .clk  (clk),
        .rst  (rst),
        .RegW (RegW),
        .Rs1  (Rs1),
        .Rs2  (Rs2),
        .Rd   (Rd),
        .Wd   (Wd),
        .rd1  (rd1),
        .rd2  (rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [XLEN-1:0] exp_fwd;

    initial begin
        rst  = 1'b0;
        RegW = 1'b0;
        Rs1  = 5'd0;
        Rs2  = 5'd1;
        Rd   = 5'd0;
        Wd   = '0;

        // Reset held
        #2;
        check("reset_held_rd1_x0", rd1, 32'h0);
        check("reset_held_rd2_r1", rd2, 32'h0);
        #10;
        rst = 1'b1;
        #1;
        check("post_reset_rd1_x0", rd1, 32'h0);
        check("post_reset_rd2_r1", rd2, 32'h0);

        // Basic write/read
        @(negedge clk);
        RegW = 1'b1; Rd = 5'd5; Wd = 32'h12345678; Rs1 = 5'd5; Rs2 = 5'd1;
        @(negedge clk);
        RegW = 1'b0;
        #1;
        check("write_r5_rd1", rd1, 32'h12345678);
        check("write_r5_rd2_r1", rd2, 32'h0);

        // Top address
        RegW = 1'b1; Rd = 5'd31; Wd = 32'hAABBCCDD;
        @(negedge clk);
        RegW = 1'b0; Rs1 = 5'd31; Rs2 = 5'd5;
        #1;
        check("write_r31_rd1", rd1, 32'hAABBCCDD);
        check("r5_kept_rd2", rd2, 32'h12345678);

        // x0 protection
        @(negedge clk);
        RegW = 1'b1; Rd = 5'd0; Wd = 32'hDEADBEEF;
        @(negedge clk);
        RegW = 1'b0; Rs1 = 5'd0; Rs2 = 5'd0;
        #1;
        check("x0_rd1", rd1, 32'h0);
        check("x0_rd2", rd2, 32'h0);
        Rs1 = 5'd31;
        #1;
        check("x0_write_r31_kept", rd1, 32'hAABBCCDD);

        // Both ports on the same register
        Rs1 = 5'd5; Rs2 = 5'd5;
        #1;
        check("same_reg_rd1", rd1, 32'h12345678);
        check("same_reg_rd2", rd2, 32'h12345678);

        // Same-cycle read of a register being written
        @(negedge clk);
        RegW = 1'b1; Rd = 5'd9; Wd = 32'hCAFEF00D; Rs1 = 5'd9; Rs2 = 5'd31;
`ifdef REG_FILE_BYPASS_EN
        exp_fwd = 32'hCAFEF00D;
`else
        exp_fwd = 32'h0;
`endif
        #1;
        check("same_cycle_r9_rd1", rd1, exp_fwd);
        check("same_cycle_other_rd2", rd2, 32'hAABBCCDD);
        @(negedge clk);
        RegW = 1'b0;
        #1;
        check("after_edge_r9_rd1", rd1, 32'hCAFEF00D);

        // Write to x0 must never forward
        RegW = 1'b1; Rd = 5'd0; Wd = 32'h5555AAAA; Rs1 = 5'd0; Rs2 = 5'd0;
        #1;
        check("x0_no_fwd_rd1", rd1, 32'h0);
        check("x0_no_fwd_rd2", rd2, 32'h0);
        @(negedge clk);
        RegW = 1'b0;

        // RegW gating
        Rd = 5'd7; Wd = 32'h1; Rs1 = 5'd7; Rs2 = 5'd9;
        @(negedge clk);
        #1;
        check("regw_low_r7", rd1, 32'h0);
        check("regw_low_r9_kept", rd2, 32'hCAFEF00D);

        // Asynchronous reset between edges
        @(negedge clk);
        Rs1 = 5'd31; Rs2 = 5'd9;
        #1;
        check("pre_async_r31", rd1, 32'hAABBCCDD);
        rst = 1'b0;
        #1;
        check("async_reset_r31", rd1, 32'h0);
        check("async_reset_r9", rd2, 32'h0);

        // Write attempted while reset is held is discarded
        RegW = 1'b1; Rd = 5'd3; Wd = 32'h00000055; Rs1 = 5'd3;
        @(negedge clk);
        RegW = 1'b0;
        rst = 1'b1;
        #1;
        check("write_during_reset_r3", rd1, 32'h0);

        // Normal write works after reset release
        RegW = 1'b1; Rd = 5'd3; Wd = 32'h0F0F0F0F;
        @(negedge clk);
        RegW = 1'b0;
        #1;
        check("post_reset_write_r3", rd1, 32'h0F0F0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000;
        failures++;
        $display("FAIL timeout checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
